// File: rtl/memory_controller_if.sv
// Requester and RAM-side signal bundle for the shared byte-wide memory port.
// slave = controller side, master = the core/RAM environment side.
interface memory_controller_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  inst_valid;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  inst_flush;
  logic                  inst_done;
  logic [31:0]           inst_rdata;
  logic                  data_valid;
  logic                  data_write;
  logic [1:0]            data_size;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [31:0]           data_wdata;
  logic                  data_done;
  logic [31:0]           data_rdata;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  modport slave (
    input  inst_valid, inst_addr, inst_flush,
    input  data_valid, data_write, data_size, data_addr, data_wdata,
    input  mem_din,
    output inst_done, inst_rdata, data_done, data_rdata,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output inst_valid, inst_addr, inst_flush,
    output data_valid, data_write, data_size, data_addr, data_wdata,
    output mem_din,
    input  inst_done, inst_rdata, data_done, data_rdata,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/memory_controller.sv
// Round-robin arbiter between instruction fetch and load/store unit that
// serialises each request into byte accesses on a registered single-port RAM.
module memory_controller #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rdy,
  memory_controller_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t                r_state;
  logic                  r_last_data;
  logic                  r_is_data;
  logic [2:0]            r_cnt;
  logic [2:0]            r_nbytes;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [7:0]            r_mem_dout;
  logic                  r_mem_wr;
  logic                  r_inst_done;
  logic                  r_data_done;
  logic [DATA_WIDTH-1:0] r_inst_rdata;
  logic [DATA_WIDTH-1:0] r_data_rdata;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_inst_req;
  logic                  w_data_req;
  logic                  w_grant_data;
  logic [2:0]            w_data_n;
  logic [1:0]            w_cap_idx;
  logic [1:0]            w_nidx;
  logic [DATA_WIDTH-1:0] w_buf_next;
  logic [7:0]            w_next_byte;

  assign w_inst_req   = bus.inst_valid & ~bus.inst_flush;
  assign w_data_req   = bus.data_valid;
  // On contention the requester that did not win last time gets the port
  assign w_grant_data = w_data_req & (~w_inst_req | ~r_last_data);
  assign w_cap_idx    = 2'(r_cnt - 3'd1);
  assign w_nidx       = 2'(r_cnt + 3'd1);

  always_comb begin
    w_data_n = 3'd4;
    case (bus.data_size)
      2'd0:    w_data_n = 3'd1;
      2'd1:    w_data_n = 3'd2;
      default: w_data_n = 3'd4;
    endcase
  end

  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[{w_cap_idx, 3'b000} +: 8] = bus.mem_din;
    w_next_byte = r_wdata[{w_nidx, 3'b000} +: 8];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_last_data  <= 1'b1;
      r_is_data    <= 1'b0;
      r_cnt        <= '0;
      r_nbytes     <= '0;
      r_mem_a      <= '0;
      r_mem_dout   <= '0;
      r_mem_wr     <= 1'b0;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_buf        <= '0;
      r_wdata      <= '0;
    end else if (i_rdy) begin
      case (r_state)
        S_IDLE: begin
          if (w_inst_req || w_data_req) begin
            r_last_data <= w_grant_data;
            r_is_data   <= w_grant_data;
            r_cnt       <= '0;
            r_buf       <= '0;
            if (w_grant_data) begin
              r_mem_a  <= bus.data_addr;
              r_nbytes <= w_data_n;
              r_wdata  <= bus.data_wdata;
              if (bus.data_write) begin
                r_state    <= S_WRITE;
                r_mem_dout <= bus.data_wdata[7:0];
                r_mem_wr   <= 1'b1;
              end else begin
                r_state <= S_READ;
              end
            end else begin
              r_mem_a  <= bus.inst_addr;
              r_nbytes <= 3'd4;
              r_state  <= S_READ;
            end
          end
        end
        S_READ: begin
          // r_cnt = j in cycle c(j+1): address j is out, byte j-1 is on mem_din
          if (!r_is_data && bus.inst_flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_cnt != 3'd0) r_buf <= w_buf_next;
            if (r_cnt == r_nbytes) begin
              r_state <= S_DONE;
              if (r_is_data) begin
                r_data_rdata <= w_buf_next;
                r_data_done  <= 1'b1;
              end else begin
                r_inst_rdata <= w_buf_next;
                r_inst_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 3'd1;
              if (r_cnt + 3'd1 < r_nbytes) r_mem_a <= r_mem_a + ADDR_WIDTH'(1);
            end
          end
        end
        S_WRITE: begin
          if (r_cnt == r_nbytes - 3'd1) begin
            r_mem_wr    <= 1'b0;
            r_state     <= S_DONE;
            r_data_done <= 1'b1;
          end else begin
            r_cnt      <= r_cnt + 3'd1;
            r_mem_a    <= r_mem_a + ADDR_WIDTH'(1);
            r_mem_dout <= w_next_byte;
          end
        end
        default: begin
          r_inst_done <= 1'b0;
          r_data_done <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_a      = r_mem_a;
  assign bus.mem_dout   = r_mem_dout;
  assign bus.mem_wr     = r_mem_wr & i_rdy;
  assign bus.inst_done  = r_inst_done;
  assign bus.data_done  = r_data_done;
  assign bus.inst_rdata = r_inst_rdata;
  assign bus.data_rdata = r_data_rdata;
endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a registered byte RAM model.
module tb_memory_controller;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  memory_controller_if #(.ADDR_WIDTH(AW)) bus ();

  memory_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_rdy (rdy),
    .bus   (bus)
  );

  bit   [7:0]    ram [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.mem_wr) ram[bus.mem_a] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.inst_valid = 1'b0; bus.inst_addr = '0; bus.inst_flush = 1'b0;
    bus.data_valid = 1'b0; bus.data_write = 1'b0; bus.data_size = 2'd0;
    bus.data_addr = '0; bus.data_wdata = '0;
    tick(); tick();
    poke(17'h00004, 8'h13); poke(17'h00005, 8'h05);
    poke(17'h00006, 8'h00); poke(17'h00007, 8'h00);
    poke(17'h1FFFF, 8'h34); poke(17'h00000, 8'h12);
    poke(17'h00010, 8'h11); poke(17'h00011, 8'h22);
    poke(17'h00012, 8'h33); poke(17'h00013, 8'h44);

    chk("rst_mem_a", 32'(bus.mem_a), 32'h0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
    chk("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
    chk("rst_inst_done", 32'(bus.inst_done), 32'h0);
    chk("rst_data_done", 32'(bus.data_done), 32'h0);
    chk("rst_inst_rdata", bus.inst_rdata, 32'h0);
    chk("rst_data_rdata", bus.data_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // inst word read at 0x4
    bus.inst_valid = 1'b1; bus.inst_addr = 17'h00004;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("inst_mem_a", 32'(bus.mem_a), 32'h4 + 32'(k));
      chk("inst_done_early", 32'(bus.inst_done), 32'h0);
      chk("inst_mem_wr", 32'(bus.mem_wr), 32'h0);
    end
    tick();
    chk("inst_done_c5", 32'(bus.inst_done), 32'h0);
    tick();
    chk("inst_done_c6", 32'(bus.inst_done), 32'h1);
    chk("inst_rdata", bus.inst_rdata, 32'h00000513);
    bus.inst_valid = 1'b0;
    tick();
    chk("inst_done_c7", 32'(bus.inst_done), 32'h0);

    // byte store
    bus.data_valid = 1'b1; bus.data_write = 1'b1; bus.data_size = 2'd0;
    bus.data_addr = 17'h01000; bus.data_wdata = 32'h123456AB;
    tick();
    chk("st_mem_wr_c1", 32'(bus.mem_wr), 32'h1);
    chk("st_mem_a_c1", 32'(bus.mem_a), 32'h01000);
    chk("st_mem_dout_c1", 32'(bus.mem_dout), 32'hAB);
    chk("st_done_c1", 32'(bus.data_done), 32'h0);
    tick();
    chk("st_mem_wr_c2", 32'(bus.mem_wr), 32'h0);
    chk("st_done_c2", 32'(bus.data_done), 32'h1);
    bus.data_valid = 1'b0;
    tick();
    chk("st_mem_wr_c3", 32'(bus.mem_wr), 32'h0);
    chk("st_done_c3", 32'(bus.data_done), 32'h0);
    chk("st_ram_1000", 32'(ram[17'h01000]), 32'hAB);
    chk("st_ram_1001", 32'(ram[17'h01001]), 32'h00);

    // arbitration: both request, inst first, then data, then inst again
    bus.inst_valid = 1'b1; bus.inst_addr = 17'h00004;
    bus.data_valid = 1'b1; bus.data_write = 1'b0; bus.data_size = 2'd0;
    bus.data_addr = 17'h01000;
    tick();
    chk("arb_first_inst", 32'(bus.mem_a), 32'h4);
    repeat (5) tick();
    chk("arb_inst_done", 32'(bus.inst_done), 32'h1);
    tick();
    tick();
    chk("arb_then_data", 32'(bus.mem_a), 32'h01000);
    tick(); tick();
    chk("arb_data_done", 32'(bus.data_done), 32'h1);
    chk("arb_data_rdata", bus.data_rdata, 32'h000000AB);
    tick();
    tick();
    chk("arb_alternate_inst", 32'(bus.mem_a), 32'h4);
    bus.data_valid = 1'b0;
    repeat (5) tick();
    chk("arb_inst_done2", 32'(bus.inst_done), 32'h1);
    bus.inst_valid = 1'b0;
    tick();

    // halfword load wrapping the top of the address space
    bus.data_valid = 1'b1; bus.data_write = 1'b0; bus.data_size = 2'd1;
    bus.data_addr = 17'h1FFFF;
    tick();
    chk("half_mem_a_c1", 32'(bus.mem_a), 32'h1FFFF);
    tick();
    chk("half_mem_a_c2", 32'(bus.mem_a), 32'h00000);
    tick();
    chk("half_done_c3", 32'(bus.data_done), 32'h0);
    tick();
    chk("half_done_c4", 32'(bus.data_done), 32'h1);
    chk("half_rdata", bus.data_rdata, 32'h00001234);
    bus.data_valid = 1'b0;
    tick();

    // flush an inst read while a data word load waits
    bus.inst_valid = 1'b1; bus.inst_addr = 17'h00004;
    bus.data_valid = 1'b1; bus.data_write = 1'b0; bus.data_size = 2'd2;
    bus.data_addr = 17'h00010;
    tick();
    chk("fl_inst_granted", 32'(bus.mem_a), 32'h4);
    tick(); tick();
    bus.inst_flush = 1'b1; bus.inst_valid = 1'b0;
    tick();
    bus.inst_flush = 1'b0;
    chk("fl_no_done_c4", 32'(bus.inst_done), 32'h0);
    tick();
    chk("fl_data_grant", 32'(bus.mem_a), 32'h00010);
    chk("fl_no_done_c5", 32'(bus.inst_done), 32'h0);
    tick();
    chk("fl_no_done_c6", 32'(bus.inst_done), 32'h0);
    repeat (4) tick();
    chk("fl_data_done", 32'(bus.data_done), 32'h1);
    chk("fl_data_rdata", bus.data_rdata, 32'h44332211);
    chk("fl_inst_rdata_kept", bus.inst_rdata, 32'h00000513);
    bus.data_valid = 1'b0;
    tick();

    // rdy low in IDLE holds everything
    rdy = 1'b0;
    bus.data_valid = 1'b1; bus.data_write = 1'b1; bus.data_size = 2'd2;
    bus.data_addr = 17'h00100; bus.data_wdata = 32'hDDCCBBAA;
    tick();
    chk("rdy_hold_a1", 32'(bus.mem_a), 32'h13);
    chk("rdy_hold_wr", 32'(bus.mem_wr), 32'h0);
    tick();
    chk("rdy_hold_a2", 32'(bus.mem_a), 32'h13);
    chk("rdy_hold_done", 32'(bus.data_done), 32'h0);
    rdy = 1'b1;

    // reset in the middle of a word store
    tick();
    chk("rs_wr_c1", 32'(bus.mem_wr), 32'h1);
    chk("rs_a_c1", 32'(bus.mem_a), 32'h00100);
    chk("rs_dout_c1", 32'(bus.mem_dout), 32'hAA);
    tick();
    chk("rs_wr_c2", 32'(bus.mem_wr), 32'h1);
    chk("rs_a_c2", 32'(bus.mem_a), 32'h00101);
    chk("rs_dout_c2", 32'(bus.mem_dout), 32'hBB);
    rst = 1'b1; bus.data_valid = 1'b0;
    tick();
    chk("rs_wr_c3", 32'(bus.mem_wr), 32'h0);
    chk("rs_a_c3", 32'(bus.mem_a), 32'h0);
    chk("rs_dout_c3", 32'(bus.mem_dout), 32'h0);
    chk("rs_done_c3", 32'(bus.data_done), 32'h0);
    chk("rs_drdata_c3", bus.data_rdata, 32'h0);
    chk("rs_irdata_c3", bus.inst_rdata, 32'h0);
    rst = 1'b0;
    tick();
    chk("rs_done_after", 32'(bus.data_done), 32'h0);
    chk("rs_ram_100", 32'(ram[17'h00100]), 32'hAA);
    chk("rs_ram_101", 32'(ram[17'h00101]), 32'hBB);
    chk("rs_ram_102", 32'(ram[17'h00102]), 32'h00);
    chk("rs_ram_103", 32'(ram[17'h00103]), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
